prog_divider: RTL and testbench
===============================

# prog_divider

Runtime-programmable clock-enable and tick generator that replaces fixed-count dividers in the design. It emits a one-cycle `oTick` every D enabled cycles and a 50 % duty `oSquare` of period 2·D. Software or control logic loads D at run time; a new value takes effect only on a period boundary, so no period is ever truncated. The block sits between the system clock and every slow consumer: display refresh, debouncers, seconds counters and blink logic.

## Interface
- `WIDTH`, default 26: width of the divisor and counter.
- `DEFAULT_DIV`, default 50000000: period D loaded at reset. Must fit in WIDTH bits.

Ports:
- `iClk`, in, 1: system clock, rising edge.
- `iRst`, in, 1: asynchronous active-high reset.
- `iEn`, in, 1: count enable. Low freezes the counter and `oSquare`.
- `iSync`, in, 1: synchronous restart of the counter phase.
- `iLoad`, in, 1: one-cycle strobe that captures `iDiv` as the pending period.
- `iDiv`, in, WIDTH: new period D. 0 is treated as 1.
- `oTick`, out, 1: registered one-cycle pulse, once per period.
- `oSquare`, out, 1: registered square wave that toggles on every tick.
- `oPending`, out, 1: a loaded period is waiting to be applied.
- `oCount`, out, WIDTH: current counter value, for debug and observation.

## Operation
- Registers:
  - period P, reset DEFAULT_DIV.
  - pending value N, reset 0.
  - pending flag, reset 0.
  - counter C, reset 0.
  - `oTick`, reset 0.
  - `oSquare`, reset 0.
- All outputs reset to 0.
- Enabled edge (iEn=1, iSync=0):
  - If C == P−1: C←0, `oTick`←1, `oSquare` toggles. If the pending flag is set, P←N and the flag clears on the same edge.
  - Otherwise: C←C+1, `oTick`←0.
- Disabled edge (iEn=0, iSync=0):
  - C and `oSquare` hold; `oTick`←0.
  - If the pending flag is set, P←N and the flag clears immediately. C is not changed.
  - If C ≥ new P, the next enabled edge counts as terminal.
- iSync=1, overrides iEn:
  - C←0, `oTick`←0, `oSquare`←0.
  - If the pending flag is set, P←N and the flag clears.
- Load:
  - iLoad=1 captures N←max(iDiv,1) and sets the pending flag.
  - Same-edge application: iLoad in the same cycle as a terminal count, iSync or iEn=0 applies the new value directly to P on that edge. The flag never rises.
  - A second iLoad while pending overwrites N. The last load wins.
- Comparison rule: the terminal test is C ≥ P−1, not equality. This guarantees recovery after P shrinks below C.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - P−1 is computed on P ≥ 1 only, so it never underflows.
  - C never exceeds 2^WIDTH−1.

## Timing
- `oPending` mirrors the pending flag, registered. It is high from the edge after iLoad up to and including the edge that applies N.
- First tick: iRst deasserts, then iEn is held high from edge 1. `oTick` is high in the cycle following edge D.
- Tick period: exactly D cycles while enabled. `oTick` width: exactly 1 cycle.
- D=1: `oTick` is high continuously while enabled, and `oSquare` toggles every cycle.
- Output latency: every output is a register, with zero combinational paths from inputs to outputs.
- Reset mid-period: reset clears the count, the pending load and the outputs immediately and asynchronously. P returns to DEFAULT_DIV.
- iEn dropping during the tick edge: the tick already registered still appears for one cycle. No further ticks occur until the block is re-enabled.
- iSync and the terminal count on the same edge: iSync wins. There is no tick and `oSquare` is forced to 0.

## Test plan
- **Reset and free run:** DEFAULT_DIV=5, iEn=1 after reset.
  - `oTick` pulses at cycles 5, 10 and 15, each 1 cycle wide.
  - `oSquare` rises at 5 and falls at 10.
  - All outputs are 0 during reset.
- **Deferred load:** running with P=5 and C=2, pulse iLoad with iDiv=3.
  - `oPending`=1 until the tick 3 cycles later.
  - The following ticks are spaced 3 cycles apart.
- **Load while disabled and shrink:** hold C at 6 with P=8 and iEn=0, then load iDiv=4.
  - P=4 on the next edge and `oPending` never asserts.
  - When re-enabled, a tick occurs on the first enabled edge, then every 4 cycles.
- **Edge values:** load iDiv=0.
  - Behaves as D=1: `oTick` is held high and `oSquare` toggles every cycle.
  - Then load iDiv=2^WIDTH−1 (small WIDTH=4 build, value 15): ticks are spaced 15 cycles apart with no wrap glitch.
- **Sync restart:** assert iSync on the terminal-count cycle.
  - No tick and `oSquare`=0.
  - The next tick comes exactly P cycles after iSync deasserts.
- **Asynchronous reset mid-operation:** assert iRst between clock edges while `oPending`=1 and C≠0.
  - All outputs drop to 0 without waiting for a clock edge.
  - After release, P=DEFAULT_DIV: the pending load is discarded.

Source files
------------

// File: rtl/prog_divider.sv
// Runtime-programmable tick / square-wave divider. A loaded period waits for the
// next period boundary (terminal count, sync restart or disabled edge) before use.
module prog_divider #(
    parameter int          WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iSync,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iDiv,
    output logic             oTick,
    output logic             oSquare,
    output logic             oPending,
    output logic [WIDTH-1:0] oCount
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_RST = (DEFAULT_DIV == 0) ? ONE : WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             square_q, square_d;

    logic [WIDTH-1:0] div_eff;
    logic             terminal;
    logic             boundary;

    assign div_eff  = (iDiv == '0) ? ONE : iDiv;
    // Greater-or-equal so a counter stranded above a shrunken period still terminates.
    assign terminal = (count_q >= (period_q - ONE));
    assign boundary = iSync | ~iEn | terminal;

    always_comb begin
        count_d  = count_q;
        tick_d   = 1'b0;
        square_d = square_q;
        if (iSync) begin
            count_d  = '0;
            square_d = 1'b0;
        end else if (iEn) begin
            if (terminal) begin
                count_d  = '0;
                tick_d   = 1'b1;
                square_d = ~square_q;
            end else begin
                count_d  = count_q + ONE;
            end
        end
    end

    // A load arriving on a boundary edge goes straight to the period register.
    always_comb begin
        period_d   = period_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        if (boundary && pend_q) begin
            period_d = pend_val_q;
            pend_d   = 1'b0;
        end
        if (iLoad) begin
            if (boundary) begin
                period_d = div_eff;
                pend_d   = 1'b0;
            end else begin
                pend_val_d = div_eff;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            period_q   <= P_RST;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            square_q   <= 1'b0;
        end else begin
            period_q   <= period_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            square_q   <= square_d;
        end
    end

    assign oTick    = tick_q;
    assign oSquare  = square_q;
    assign oPending = pend_q;
    assign oCount   = count_q;

endmodule

// File: tb/tb_prog_divider.sv
// Bench for prog_divider (WIDTH=4, DEFAULT_DIV=5): vector table, directed corner
// sequences and randomized traffic against a behavioural period model.
module tb_prog_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, sync, load;
    logic [W-1:0] div;
    logic         tick, square, pending;
    logic [W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_period, m_count, m_pend_val;
    bit m_pend, m_tick, m_sq;

    prog_divider #(.WIDTH(W), .DEFAULT_DIV(5)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iEn     (en),
        .iSync   (sync),
        .iLoad   (load),
        .iDiv    (div),
        .oTick   (tick),
        .oSquare (square),
        .oPending(pending),
        .oCount  (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en, sync, load;
        int div;
        bit tick, sq, pend;
        int cnt;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_period = 5; m_count = 0; m_pend_val = 0;
        m_pend = 0; m_tick = 0; m_sq = 0;
    endtask

    // One clock edge of the period/phase rules, in plain integer arithmetic.
    task automatic model_edge(input bit e, input bit s, input bit l, input int d);
        int  nd;
        bit  bnd;
        nd = (d == 0) ? 1 : d;
        if (s) begin
            m_count = 0; m_tick = 0; m_sq = 0; bnd = 1;
        end else if (!e) begin
            m_tick = 0; bnd = 1;
        end else if (m_count + 1 >= m_period) begin
            m_count = 0; m_tick = 1; m_sq = !m_sq; bnd = 1;
        end else begin
            m_count = m_count + 1; m_tick = 0; bnd = 0;
        end
        if (bnd && m_pend) begin
            m_period = m_pend_val; m_pend = 0;
        end
        if (l) begin
            if (bnd) m_period = nd;
            else begin m_pend_val = nd; m_pend = 1; end
        end
    endtask

    task automatic compare_model();
        check("model_tick",    int'(tick),    int'(m_tick));
        check("model_square",  int'(square),  int'(m_sq));
        check("model_pending", int'(pending), int'(m_pend));
        check("model_count",   int'(count),   m_count);
    endtask

    // Drive at a falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input bit e, input bit s, input bit l, input int d);
        en = e; sync = s; load = l; div = W'(d);
        @(posedge clk);
        model_edge(e, s, l, d);
        @(negedge clk);
        load = 1'b0;
        compare_model();
    endtask

    task automatic run_until_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step(1, 0, 0, 0);
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        bit prev_sq;

        tbl[0]  = '{1,0,0,0, 0,0,0,1};
        tbl[1]  = '{1,0,0,0, 0,0,0,2};
        tbl[2]  = '{1,0,0,0, 0,0,0,3};
        tbl[3]  = '{1,0,0,0, 0,0,0,4};
        tbl[4]  = '{1,0,0,0, 1,1,0,0};
        tbl[5]  = '{1,0,0,0, 0,1,0,1};
        tbl[6]  = '{1,0,0,0, 0,1,0,2};
        tbl[7]  = '{1,0,1,3, 0,1,1,3};
        tbl[8]  = '{1,0,0,0, 0,1,1,4};
        tbl[9]  = '{1,0,0,0, 1,0,0,0};
        tbl[10] = '{1,0,0,0, 0,0,0,1};
        tbl[11] = '{1,0,0,0, 0,0,0,2};
        tbl[12] = '{1,0,0,0, 1,1,0,0};
        tbl[13] = '{1,0,0,0, 0,1,0,1};
        tbl[14] = '{1,0,0,0, 0,1,0,2};
        tbl[15] = '{1,0,0,0, 1,0,0,0};

        rst = 1'b1; en = 1'b0; sync = 1'b0; load = 1'b0; div = '0;
        model_reset();
        @(negedge clk);
        check("rst_tick",    int'(tick),    0);
        check("rst_square",  int'(square),  0);
        check("rst_pending", int'(pending), 0);
        check("rst_count",   int'(count),   0);
        @(negedge clk);
        rst = 1'b0;

        // Free run from reset, then a deferred load of 3 at C=2
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].sync, tbl[i].load, tbl[i].div);
            check($sformatf("tbl%0d_tick", i),    int'(tick),    int'(tbl[i].tick));
            check($sformatf("tbl%0d_square", i),  int'(square),  int'(tbl[i].sq));
            check($sformatf("tbl%0d_pending", i), int'(pending), int'(tbl[i].pend));
            check($sformatf("tbl%0d_count", i),   int'(count),   tbl[i].cnt);
        end

        // Load while disabled, then shrink the period below the held count
        step(0, 0, 1, 8);
        check("shrink_p8_pending", int'(pending), 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        check("shrink_count6", int'(count), 6);
        step(0, 0, 0, 0);
        check("shrink_hold_count", int'(count), 6);
        step(0, 0, 1, 4);
        check("shrink_no_pending", int'(pending), 0);
        check("shrink_count_kept", int'(count), 6);
        step(1, 0, 0, 0);
        check("shrink_first_tick", int'(tick), 1);
        check("shrink_first_count", int'(count), 0);
        run_until_tick(20, n);
        check("shrink_spacing_a", n, 4);
        run_until_tick(20, n);
        check("shrink_spacing_b", n, 4);

        // iDiv=0 behaves as D=1
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            prev_sq = square;
            step(1, 0, 0, 0);
            check($sformatf("d1_tick%0d", i), int'(tick), 1);
            check($sformatf("d1_square%0d", i), int'(square), int'(!prev_sq));
        end

        // Largest period in a 4-bit build
        step(0, 0, 1, 15);
        run_until_tick(40, n);
        check("d15_spacing_a", n, 15);
        run_until_tick(40, n);
        check("d15_spacing_b", n, 15);

        // Sync restart landing on the terminal-count edge
        step(1, 1, 1, 5);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        check("sync_pre_count", int'(count), 4);
        step(1, 1, 0, 0);
        check("sync_no_tick", int'(tick), 0);
        check("sync_square0", int'(square), 0);
        check("sync_count0", int'(count), 0);
        run_until_tick(20, n);
        check("sync_next_tick", n, 5);

        // Asynchronous reset while a load is pending
        step(1, 0, 0, 0);
        step(1, 0, 1, 7);
        check("areset_pre_pending", int'(pending), 1);
        check("areset_pre_count", int'(count), 2);
        #2 rst = 1'b1;
        #1;
        check("areset_tick",    int'(tick),    0);
        check("areset_square",  int'(square),  0);
        check("areset_pending", int'(pending), 0);
        check("areset_count",   int'(count),   0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_until_tick(20, n);
        check("areset_default_period", n, 5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
